// File: rtl/noc_arb_pkg.sv
// Shared helpers for the NoC output-port arbiters: width derivation,
// one-hot/index conversion and the arbiter state encoding.
package noc_arb_pkg;

    localparam int ARB_MAX_N = 64;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Index/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [ARB_MAX_N-1:0] idx2onehot(input int unsigned idx);
        logic [ARB_MAX_N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic int unsigned onehot2idx(input logic [ARB_MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first eligible requester at or after
// ptr (wrapping), returned as one-hot, binary index and an any flag.
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int N    = 5,
    parameter int ID_W = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    win_oh,
    output logic [ID_W-1:0] win_idx,
    output logic            any
);

    logic [N-1:0] elig;

    assign elig = req & mask;

    always_comb begin
        int j;
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && elig[j]) begin
                any        = 1'b1;
                win_idx    = ID_W'(j);
                win_oh[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sticky_arbiter.sv
// Round-robin output-port arbiter with wormhole lock: the winner keeps the
// grant while it requests, optionally bounded by MAX_HOLD cycles.
module rr_sticky_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N        = 5,
    parameter int MAX_HOLD = 0,
    parameter int ID_W     = clog2_min1(N),
    parameter int HOLD_W   = clog2_min1(MAX_HOLD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N - 1);

    logic [N-1:0]      gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [N-1:0]      pick_oh;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              holder_req;
    logic              at_limit;
    arb_state_e        state;

    assign state      = gnt_valid_q ? ARB_GRANT : ARB_IDLE;
    assign holder_req = |(req & gnt_q);
    assign at_limit   = (MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST);

    // Masking the current holder makes the pick "others only" at handover;
    // when idle gnt_q is zero so every requester is eligible.
    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req     (req),
        .mask    (~gnt_q),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;

        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d       = pick_oh;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = pick_idx;
                    ptr_d       = (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
                    hold_cnt_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (holder_req && !at_limit) begin
                    if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else if (pick_any) begin
                    // Direct handover, no idle bubble between packets.
                    gnt_d       = pick_oh;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = pick_idx;
                    ptr_d       = (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
                    hold_cnt_d  = '0;
                end else if (holder_req) begin
                    // Limit reached but nobody else wants the port: restart the window.
                    hold_cnt_d = '0;
                end else begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    hold_cnt_d  = '0;
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

endmodule
